// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared FSM state, mode encodings and default width for counter_seq_ctrl
package counter_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PP   = 2'b10;
    localparam logic [1:0] MODE_RSV  = 2'b11;
    localparam int DEFAULT_WIDTH = 5;
endpackage

// File: rtl/counter_seq_ctrl_step_addsub.sv
// step_addsub: modulo-2^W increment (sub=0) or decrement (sub=1)
module step_addsub #(parameter int W = 5) (
    input  logic [W-1:0] a,
    input  logic         sub,
    output logic [W-1:0] y
);
    always_comb y = sub ? a - W'(1) : a + W'(1);
endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: bounded up/down/ping-pong sequencer with hold/stop control.
// Ping-pong mode exists only when COUNTER_SEQ_PINGPONG_EN is defined; otherwise mode 10 is rejected.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             hold,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_t           state;
    logic [1:0]       mode_r;
    logic [WIDTH-1:0] lo_r, hi_r, y;
    logic             mode_ok, valid, at_end, rev, flat;
`ifdef COUNTER_SEQ_PINGPONG_EN
    // rev flips the step direction for the cycle that bounces off a bound
    always_comb begin
        mode_ok = mode != MODE_RSV;
        rev     = mode_r == MODE_PP && lo_r != hi_r && count == (dir ? lo_r : hi_r);
        flat    = mode_r == MODE_PP && lo_r == hi_r;
    end
`else
    always_comb begin
        mode_ok = mode == MODE_UP || mode == MODE_DOWN;
        rev     = 1'b0;
        flat    = 1'b0;
    end
`endif
    always_comb begin
        valid  = mode_ok && lo <= hi;
        at_end = (mode_r == MODE_UP && count == hi_r) || (mode_r == MODE_DOWN && count == lo_r);
    end
    step_addsub #(.W(WIDTH)) u_step (.a(count), .sub(dir ^ rev), .y(y));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode_r <= '0;
            lo_r   <= '0;
            hi_r   <= '0;
            count  <= '0;
            dir    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (valid) begin
                        mode_r <= mode;
                        lo_r   <= lo;
                        hi_r   <= hi;
                        count  <= mode == MODE_DOWN ? hi : lo;
                        dir    <= mode == MODE_DOWN;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
                RUN: if (stop || (!hold && at_end)) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else if (!hold && !flat) begin
                    count <= y;
                    dir   <= dir ^ rev;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: randomized self-checking bench against a value-list / triangle-wave reference model
module tb_counter_seq_ctrl;
    import counter_seq_pkg::*;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n, start, hold, stop;
    logic [1:0]   mode;
    logic [W-1:0] lo, hi, count;
    logic         dir, busy, done, err;
    int           compared = 0, mismatched = 0;
    logic [W-1:0] exp_count;
    logic         exp_dir;

    counter_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .lo(lo), .hi(hi),
        .hold(hold), .stop(stop), .count(count), .dir(dir), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; stop = 1'b0; mode = '0; lo = '0; hi = '0;
        tick; tick;
        compared++;
        if ({count, dir, busy, done, err} !== '0)
            begin mismatched++; $display("FAIL reset_state: got %b want 0", {count, dir, busy, done, err}); end
        rst_n = 1'b1;
        exp_count = '0; exp_dir = 1'b0;
    endtask

    // vals holds the sweep in visiting order; idx only advances on non-hold cycles
    task automatic run_sweep(input logic [1:0] m, input int l, input int h,
                             input int hold_val, input int hold_len, input int hold_pct);
        int vals[$];
        int idx, hcnt, tmp, last;
        bit held_once, fin, h_now;
        logic [W-1:0] ev;
        vals = {};
        for (int v = l; v <= h; v++) if (m == MODE_UP) vals.push_back(v); else vals.push_front(v);
        start = 1'b1; mode = m; lo = l[W-1:0]; hi = h[W-1:0];
        tick;
        idx = 0; hcnt = 0; held_once = 0; fin = 0;
        for (int c = 0; c < 300 && !fin; c++) begin
            tmp = vals[idx]; ev = tmp[W-1:0];
            compared++;
            if ({busy, done, dir, count} !== {1'b1, 1'b0, m == MODE_DOWN, ev})
                begin mismatched++; $display("FAIL sweep_run: got busy/done/dir/count=%b/%b/%b/%0d want 1/0/%b/%0d", busy, done, dir, count, m == MODE_DOWN, ev); end
            if (!held_once && tmp == hold_val) begin hcnt = hold_len; held_once = 1; end
            h_now = hcnt > 0 || ($urandom_range(99) < hold_pct);
            if (hcnt > 0) hcnt--;
            hold = h_now;
            start = $urandom_range(1) == 1; mode = 2'($urandom); lo = W'($urandom); hi = W'($urandom);
            tick;
            if (!h_now) begin
                if (idx == vals.size() - 1) fin = 1; else idx++;
            end
        end
        hold = 1'b0; start = 1'b0;
        last = vals[vals.size() - 1]; ev = last[W-1:0];
        compared++;
        if (!fin || {busy, done, count} !== {1'b0, 1'b1, ev})
            begin mismatched++; $display("FAIL sweep_done: fin=%0d got busy/done/count=%b/%b/%0d want 0/1/%0d", fin, busy, done, count, ev); end
        tick;
        compared++;
        if ({busy, done, err, count} !== {3'b000, ev})
            begin mismatched++; $display("FAIL sweep_idle: got busy/done/err/count=%b/%b/%b/%0d want 0/0/0/%0d", busy, done, err, count, ev); end
        exp_count = ev; exp_dir = m == MODE_DOWN;
    endtask

    task automatic test_invalid(input logic [1:0] m, input int l, input int h);
        start = 1'b1; mode = m; lo = l[W-1:0]; hi = h[W-1:0];
        tick;
        start = 1'b0;
        compared++;
        if ({err, busy, done, dir, count} !== {3'b100, exp_dir, exp_count})
            begin mismatched++; $display("FAIL invalid_err: got err/busy/done/dir/count=%b/%b/%b/%b/%0d want 1/0/0/%b/%0d", err, busy, done, dir, count, exp_dir, exp_count); end
        tick;
        compared++;
        if ({err, busy, done} !== 3'b000)
            begin mismatched++; $display("FAIL invalid_after: got err/busy/done=%b%b%b want 000", err, busy, done); end
    endtask

    // Triangle wave: phase k advances on non-hold cycles, period 2*(hi-lo)
    task automatic run_pp(input int l, input int h, input int n, input int hold_pct);
`ifdef COUNTER_SEQ_PINGPONG_EN
        int k, span, p, ph, v;
        logic ed;
        logic [W-1:0] ev;
        bit h_now;
        start = 1'b1; mode = MODE_PP; lo = l[W-1:0]; hi = h[W-1:0];
        tick;
        start = 1'b0;
        k = 0; span = h - l; p = 2 * span;
        v = l; ed = 1'b0;
        for (int c = 0; c <= n; c++) begin
            if (span == 0) begin v = l; ed = 1'b0; end
            else begin
                ph = k % p;
                v  = l + (ph <= span ? ph : p - ph);
                ed = ph > span || (k > 0 && ph == 0);
            end
            ev = W'(v);
            compared++;
            if ({busy, done, dir, count} !== {2'b10, ed, ev})
                begin mismatched++; $display("FAIL pp_run: k=%0d got busy/done/dir/count=%b/%b/%b/%0d want 1/0/%b/%0d", k, busy, done, dir, count, ed, ev); end
            if (c == n) break;
            h_now = $urandom_range(99) < hold_pct;
            hold = h_now;
            tick;
            if (!h_now) k++;
        end
        stop = 1'b1; hold = $urandom_range(1) == 1;
        tick;
        stop = 1'b0; hold = 1'b0;
        compared++;
        if ({busy, done, count} !== {2'b01, ev})
            begin mismatched++; $display("FAIL pp_stop: got busy/done/count=%b/%b/%0d want 0/1/%0d", busy, done, count, ev); end
        tick;
        exp_count = ev; exp_dir = ed;
`else
        test_invalid(MODE_PP, l, h);
        n = n + hold_pct;
`endif
    endtask

    task automatic test_stop_hold;
        start = 1'b1; mode = MODE_UP; lo = 5'd2; hi = 5'd20;
        tick;
        start = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            compared++;
            if ({busy, count} !== {1'b1, W'(i)})
                begin mismatched++; $display("FAIL stop_run: got busy/count=%b/%0d want 1/%0d", busy, count, i); end
            if (i < 5) tick;
        end
        stop = 1'b1; hold = 1'b1;
        tick;
        stop = 1'b0; hold = 1'b0;
        compared++;
        if ({busy, done, count} !== {2'b01, 5'd5})
            begin mismatched++; $display("FAIL stop_hold_prio: got busy/done/count=%b/%b/%0d want 0/1/5", busy, done, count); end
        tick;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        compared++;
        if ({busy, done, count} !== {2'b00, 5'd5})
            begin mismatched++; $display("FAIL stop_idle_ignored: got busy/done/count=%b/%b/%0d want 0/0/5", busy, done, count); end
        exp_count = 5'd5; exp_dir = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        start = 1'b1; mode = MODE_UP; lo = 5'd1; hi = 5'd10;
        tick;
        start = 1'b0;
        tick; tick;
        rst_n = 1'b0; start = 1'b1;
        tick;
        compared++;
        if ({count, dir, busy, done, err} !== '0)
            begin mismatched++; $display("FAIL reset_mid_run: got %b want 0", {count, dir, busy, done, err}); end
        tick;
        compared++;
        if ({count, busy} !== '0)
            begin mismatched++; $display("FAIL reset_start_ignored: got count/busy=%0d/%b want 0/0", count, busy); end
        rst_n = 1'b1;
        tick;
        start = 1'b0;
        compared++;
        if ({busy, dir, count} !== {2'b10, 5'd1})
            begin mismatched++; $display("FAIL first_start: got busy/dir/count=%b/%b/%0d want 1/0/1", busy, dir, count); end
        stop = 1'b1;
        tick;
        stop = 1'b0;
        compared++;
        if ({busy, done, count} !== {2'b01, 5'd1})
            begin mismatched++; $display("FAIL reset_stop: got busy/done/count=%b/%b/%0d want 0/1/1", busy, done, count); end
        tick;
        exp_count = 5'd1; exp_dir = 1'b0;
    endtask

    task automatic test_random;
        int l, h, t;
        for (int i = 0; i < 16; i++) begin
            l = $urandom_range(31); h = $urandom_range(31);
            if (l > h) begin t = l; l = h; h = t; end
            run_sweep($urandom_range(1) == 1 ? MODE_DOWN : MODE_UP, l, h, -1, 0, 30);
            if (i % 4 == 0) run_pp(l, h, $urandom_range(20, 4), 25);
            if (i % 4 == 1 && l != h) test_invalid(MODE_UP, h, l);
        end
    endtask

    initial begin
        test_reset;
        run_sweep(MODE_UP, 3, 6, -1, 0, 0);
        run_sweep(MODE_DOWN, 0, 4, 2, 2, 0);
        test_invalid(MODE_UP, 9, 5);
        test_invalid(MODE_RSV, 1, 5);
        run_pp(28, 30, 5, 0);
        run_pp(7, 7, 6, 0);
        test_stop_hold;
        test_reset_mid_run;
        run_sweep(MODE_UP, 0, 31, -1, 0, 0);
        run_sweep(MODE_DOWN, 0, 31, -1, 0, 0);
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
